// File: rtl/ccc_rst_pkg.sv
// Shared types and helpers for the CCC lock supervisor / reset sequencer.
package ccc_rst_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } ccc_state_e;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int unsigned clog2m1(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ccc_sync2.sv
// Two-flop synchroniser for a single asynchronous level, synchronous active-low reset to 0.
module ccc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// PLL-lock supervisor: filters the synchronised lock, then releases domain resets
// one at a time with a fixed stagger; re-asserts all on lock loss or software request.
module ccc_lock_reset_seq
  import ccc_rst_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS        = 4,
  parameter int unsigned LOCK_FILTER_CYCLES = 256,
  parameter int unsigned STAGGER_CYCLES     = 16,
  parameter int unsigned LOSS_CNT_W         = 8
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   PLL_LOCK,
  input  logic                   SW_RESET_REQ,
  input  logic                   CLEAR_CNT,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESETN,
  output logic                   ALL_READY,
  output logic [LOSS_CNT_W-1:0]  LOCK_LOST_CNT,
  output logic [STATE_W-1:0]     STATE
);

  localparam int unsigned FILT_W = clog2m1(LOCK_FILTER_CYCLES);
  localparam int unsigned STAG_W = clog2m1(STAGGER_CYCLES);
  localparam int unsigned IDX_W  = clog2m1(NUM_DOMAINS);

  logic lock_s;

  ccc_sync2 u_lock_sync (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  ccc_state_e             state_q, state_d;
  logic [FILT_W-1:0]      filter_cnt_q, filter_cnt_d;
  logic [STAG_W-1:0]      stag_cnt_q, stag_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_rstn_q, dom_rstn_d;
  logic                   all_ready_q, all_ready_d;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
  logic                   loss_evt;

  always_comb begin
    state_d      = state_q;
    filter_cnt_d = filter_cnt_q;
    stag_cnt_d   = stag_cnt_q;
    idx_d        = idx_q;
    dom_rstn_d   = dom_rstn_q;
    all_ready_d  = all_ready_q;
    loss_evt     = 1'b0;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d      = ST_FILTER;
          filter_cnt_d = '0;
        end
      end

      ST_FILTER: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (filter_cnt_q == FILT_W'(LOCK_FILTER_CYCLES - 1)) begin
          state_d    = ST_RELEASE;
          stag_cnt_d = '0;
          idx_d      = '0;
        end else begin
          filter_cnt_d = filter_cnt_q + FILT_W'(1);
        end
      end

      // RELEASE and RUN share the re-assert checks; lock loss outranks a software request.
      ST_RELEASE, ST_RUN: begin
        if (!lock_s) begin
          state_d     = ST_WAIT_LOCK;
          dom_rstn_d  = '0;
          all_ready_d = 1'b0;
          loss_evt    = 1'b1;
        end else if (SW_RESET_REQ) begin
          state_d     = ST_HOLD;
          dom_rstn_d  = '0;
          all_ready_d = 1'b0;
          stag_cnt_d  = '0;
        end else if (state_q == ST_RELEASE) begin
          if (stag_cnt_q == STAG_W'(STAGGER_CYCLES - 1)) begin
            stag_cnt_d = '0;
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
              if (idx_q == IDX_W'(i)) dom_rstn_d[i] = 1'b1;
            end
            if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
              state_d     = ST_RUN;
              all_ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            stag_cnt_d = stag_cnt_q + STAG_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (stag_cnt_q == STAG_W'(STAGGER_CYCLES - 1)) begin
          state_d    = ST_WAIT_LOCK;
          stag_cnt_d = '0;
        end else begin
          stag_cnt_d = stag_cnt_q + STAG_W'(1);
        end
      end

      default: begin
        state_d     = ST_WAIT_LOCK;
        dom_rstn_d  = '0;
        all_ready_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    if (CLEAR_CNT) loss_cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q      <= ST_WAIT_LOCK;
      filter_cnt_q <= '0;
      stag_cnt_q   <= '0;
      idx_q        <= '0;
      dom_rstn_q   <= '0;
      all_ready_q  <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      filter_cnt_q <= filter_cnt_d;
      stag_cnt_q   <= stag_cnt_d;
      idx_q        <= idx_d;
      dom_rstn_q   <= dom_rstn_d;
      all_ready_q  <= all_ready_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign DOMAIN_RESETN = dom_rstn_q;
  assign ALL_READY     = all_ready_q;
  assign LOCK_LOST_CNT = loss_cnt_q;
  assign STATE         = state_q;

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Bench for ccc_lock_reset_seq: two configurations driven in parallel, each checked
// every cycle against a timeline model kept in a scoreboard queue.
module tb_ccc_lock_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, pll_lock, sw_req, clear_cnt;

  logic [3:0] dom_a;
  logic       rdy_a;
  logic [7:0] cnt_a;
  logic [2:0] st_a;

  logic [0:0] dom_b;
  logic       rdy_b;
  logic [1:0] cnt_b;
  logic [2:0] st_b;

  ccc_lock_reset_seq #(
    .NUM_DOMAINS(4), .LOCK_FILTER_CYCLES(8), .STAGGER_CYCLES(4), .LOSS_CNT_W(8)
  ) dut_a (
    .CLK(clk), .RESETN(resetn), .PLL_LOCK(pll_lock), .SW_RESET_REQ(sw_req),
    .CLEAR_CNT(clear_cnt), .DOMAIN_RESETN(dom_a), .ALL_READY(rdy_a),
    .LOCK_LOST_CNT(cnt_a), .STATE(st_a)
  );

  ccc_lock_reset_seq #(
    .NUM_DOMAINS(1), .LOCK_FILTER_CYCLES(1), .STAGGER_CYCLES(1), .LOSS_CNT_W(2)
  ) dut_b (
    .CLK(clk), .RESETN(resetn), .PLL_LOCK(pll_lock), .SW_RESET_REQ(sw_req),
    .CLEAR_CNT(clear_cnt), .DOMAIN_RESETN(dom_b), .ALL_READY(rdy_b),
    .LOCK_LOST_CNT(cnt_b), .STATE(st_b)
  );

  // mode: 0 waiting for lock, 1 lock sequence started at edge t0, 2 hold started at edge hs
  typedef struct {
    int mode;
    int t0;
    int hs;
    int loss;
    bit h1;
    bit h2;
  } mdl_t;

  typedef struct {
    int dom;
    bit rdy;
    int cnt;
    int st;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;
  int   e_drive = -1;
  int   first_a1 = -1, first_a3 = -1, first_rdy_a = -1, first_rdy_b = -1;

  // Post-edge expectation from elapsed time since lock was seen, not from counters.
  function automatic void mstep(inout mdl_t m, output exp_t x, input int t,
                                input int n, input int l, input int s, input int w,
                                input bit rn, input bit lk, input bit sw, input bit clr);
    bit ls;
    int e0, e, rel;
    if (!rn) begin
      m.mode = 0; m.loss = 0; m.h1 = 1'b0; m.h2 = 1'b0;
    end else begin
      ls = m.h2;
      case (m.mode)
        0: if (ls) begin m.mode = 1; m.t0 = t; end
        1: begin
          e0 = t - 1 - m.t0;
          if (!ls) begin
            m.mode = 0;
            if (e0 >= l && m.loss < (1 << w) - 1) m.loss++;
          end else if (sw && e0 >= l) begin
            m.mode = 2; m.hs = t;
          end
        end
        default: if (t - m.hs == s) m.mode = 0;
      endcase
      if (clr) m.loss = 0;
      m.h2 = m.h1;
      m.h1 = lk;
    end
    x.dom = 0; x.rdy = 1'b0; x.cnt = m.loss; x.st = 0;
    if (m.mode == 2) x.st = 4;
    else if (m.mode == 1) begin
      e = t - m.t0;
      if (e < l) x.st = 1;
      else begin
        rel = (e - l) / s;
        if (rel >= n) begin rel = n; x.st = 3; x.rdy = 1'b1; end
        else x.st = 2;
        x.dom = (1 << rel) - 1;
      end
    end
  endfunction

  task automatic tick(input bit lk, input bit sw, input bit clr, input bit rn);
    exp_t x;
    pll_lock = lk; sw_req = sw; clear_cnt = clr; resetn = rn;
    @(posedge clk);
    edge_no++;
    mstep(ma, x, edge_no, 4, 8, 4, 8, rn, lk, sw, clr);
    qa.push_back(x);
    mstep(mb, x, edge_no, 1, 1, 1, 2, rn, lk, sw, clr);
    qb.push_back(x);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      checks++;
      if (dom_a !== 4'(x.dom) || rdy_a !== x.rdy || cnt_a !== 8'(x.cnt) || st_a !== 3'(x.st)) begin
        errors++;
        $display("FAIL dut_a edge %0d: got dom=%b rdy=%b cnt=%0d st=%0d want dom=%b rdy=%b cnt=%0d st=%0d",
                 edge_no, dom_a, rdy_a, cnt_a, st_a, 4'(x.dom), x.rdy, x.cnt, x.st);
      end
    end
    if (qb.size() > 0) begin
      x = qb.pop_front();
      checks++;
      if (dom_b !== 1'(x.dom) || rdy_b !== x.rdy || cnt_b !== 2'(x.cnt) || st_b !== 3'(x.st)) begin
        errors++;
        $display("FAIL dut_b edge %0d: got dom=%b rdy=%b cnt=%0d st=%0d want dom=%b rdy=%b cnt=%0d st=%0d",
                 edge_no, dom_b, rdy_b, cnt_b, st_b, 1'(x.dom), x.rdy, x.cnt, x.st);
      end
    end
    if (first_a1 < 0 && dom_a === 4'b0001) first_a1 = edge_no;
    if (first_a3 < 0 && dom_a === 4'b0011) first_a3 = edge_no;
    if (first_rdy_a < 0 && rdy_a === 1'b1) first_rdy_a = edge_no;
    if (first_rdy_b < 0 && rdy_b === 1'b1) first_rdy_b = edge_no;
  end

  initial begin
    int r, len;
    pll_lock = 1'b0; sw_req = 1'b0; clear_cnt = 1'b0; resetn = 1'b0;

    // Power-up: lock driven high just after edge e, held.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_dom_a", int'(dom_a), 0);
    chk("reset_state_a", int'(st_a), 0);
    e_drive = edge_no;
    for (int i = 0; i < 35; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("lat_dom0_a", first_a1 - e_drive, 15);
    chk("lat_dom1_a", first_a3 - e_drive, 19);
    chk("lat_ready_a", first_rdy_a - e_drive, 27);
    chk("lat_ready_b", first_rdy_b - e_drive, 5);
    chk("ready_a_run", int'(rdy_a), 1);

    // Lock loss in RUN, then glitchy relock during filtering.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("loss_cnt_a", int'(cnt_a), 1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 35; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);

    // Software reset from RUN, then coincident with lock loss.
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("coinc_state_a", int'(st_a), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-sequence reset while two domains are released.
    for (int i = 0; i < 19; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_dom_a", int'(dom_a), 3);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_dom_a", int'(dom_a), 0);
    chk("mid_reset_cnt_a", int'(cnt_a), 0);

    // Saturation of the 2-bit counter, then clear coincident with a loss.
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("sat_cnt_b", int'(cnt_b), 3);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("clear_win_b", int'(cnt_b), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomised traffic.
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 50) begin
        len = $urandom_range(1, 40);
        for (int k = 0; k < len; k++)
          tick(1'b1, $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0, 1'b1);
      end else if (r < 80) begin
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++)
          tick(1'b0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 1'b1);
      end else if (r < 90) begin
        tick(1'b1, 1'b1, 1'b0, 1'b1);
      end else if (r < 95) begin
        tick(1'b1, 1'b0, 1'b1, 1'b1);
      end else begin
        tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
